issue_queue: RTL and testbench
==============================

# issue_queue

Decoded-instruction queue between the fetch/decode stage and the execute/issue stage of the core. It captures each bundle strobed by `distinct`, along with its control fields, register fields, immediates and `pc`/`pc1`. It presents the bundles in order to the execute stage with a valid/ready handshake. It drives the `full` back-pressure that fetch/decode samples, and it discards wrong-path bundles on a branch flush.

## Interface
Parameters:
- `INST_MEM_WIDTH`, default 15: instruction-address width (`pc`, `pc1`).
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.

Ports:
- `CLK`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `distinct`  in  1: one-cycle strobe from fetch/decode meaning the bundle is valid.
- `in_ctrl`  in  `$bits(ctrl_t)`: packed decoded controls and fields.
- `in_pc`  in  `INST_MEM_WIDTH`: `pc` of the bundle.
- `in_pc1`  in  `INST_MEM_WIDTH`: `pc1` of the bundle.
- `flush`  in  1: branch redirect; discard all entries.
- `full`  out  1: back-pressure to fetch/decode.
- `issue_ready`  in  1: execute stage accepts the head entry.
- `issue_valid`  out  1: the head entry is valid.
- `issue_ctrl`  out  `$bits(ctrl_t)`: head entry controls.
- `issue_pc`  out  `INST_MEM_WIDTH`: head entry `pc`.
- `issue_pc1`  out  `INST_MEM_WIDTH`: head entry `pc1`.
- `count`  out  `$clog2(DEPTH)+1`: current occupancy.
- `overflow_err`  out  1: sticky flag set when a bundle is dropped.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` of `$clog2(DEPTH)` bits each. Pointers wrap naturally modulo `DEPTH`.
- **Push:** occurs when `distinct` is high, `flush` is low, and either `count < DEPTH` or a pop happens in the same cycle. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- **Pop:** occurs when `issue_valid && issue_ready`. `rd_ptr` then increments.
- **Occupancy:** `count` is incremented on push only, decremented on pop only, and unchanged when both or neither happen.
- **Drop:** when `distinct` is high, `count == DEPTH` and there is no pop, the bundle is discarded, `overflow_err` is set to 1 and `count` stays at `DEPTH`.
  - `overflow_err` clears only on `reset`.
- **Flush:** has priority over everything else.
  - `wr_ptr`, `rd_ptr` and `count` become 0.
  - A bundle strobed by `distinct` in the same cycle is dropped silently; it does not set `overflow_err`.
  - A pop in the same cycle is ignored.
- **`full`:** a register loaded each cycle with `next_count >= DEPTH-1`. This leaves one slot for the bundle fetch/decode already holds when it sees `full`.
- **Head outputs:** `issue_valid` is `count != 0`. `issue_ctrl`, `issue_pc` and `issue_pc1` read `mem[rd_ptr]` combinationally (show-ahead). When `count == 0` they hold stale contents.
- **No bypass:** a push into an empty queue is not forwarded in the same cycle.

## Timing
- **Reset values:** `full` 0, `issue_valid` 0, `count` 0, `overflow_err` 0. All storage and both pointers are cleared, so `issue_ctrl`, `issue_pc` and `issue_pc1` are 0.
  - Reset takes effect immediately, without waiting for a clock edge.
- **Push-to-issue latency:** a push sampled at edge N gives `issue_valid` = 1 during cycle N+1.
- **Flush:** at edge N gives `issue_valid` = 0 and `full` = 0 in cycle N+1.
- **`full` updates:** in the cycle after the push or pop that changes occupancy.
- **Sustained streaming** with `issue_ready` = 1 runs at one bundle per cycle. With one-per-cycle pushes, `count` stays at or below 1.
- **Reset mid-operation:** every in-flight entry is lost, and no flag other than the reset values remains.

## Structure
- **Package `cpu_pkg`** holds `ctrl_t`, a packed struct with the following fields:
  - `AorF`, `RegWrite`, `MemtoReg[1:0]`, `ALUSrcs[1:0]`, `ALUSrcs2`
  - `ALUOp[3:0]`, `RegDist[1:0]`, `Branch[1:0]`
  - `MemWrite`, `MemRead`, `UARTtoReg`, `RegtoUART`
  - `rs`, `rt`, `rd`, `sa` (5 bits each), `immediate[15:0]`, `inst_index[25:0]`
- **Sub-module `issue_queue_ram`** is the storage array. It has one write port and one asynchronous read port, and is cleared on `reset`.
- **`issue_queue` itself** holds the pointers, `count`, `full`, the flush logic and the error flag.

## Test plan
- **Fill:** `DEPTH`=4, `issue_ready`=0, push `pc` 1, 2, 3.
  - `count` = 3 and `full` = 1 in the cycle after the third push.
  - `issue_pc` = 1.
- **Overflow:** continuing from the fill, push `pc` 4, then `pc` 5.
  - `pc` 4 is accepted: `count` = 4, `overflow_err` = 0.
  - `pc` 5 is dropped: `overflow_err` = 1, `count` stays 4.
  - Popping then yields 1, 2, 3, 4.
- **Push and pop at `count` = 4:** push `pc` 9 with `issue_ready`=1 in the same cycle.
  - `count` stays 4 and `overflow_err` stays 0.
  - The queue drains 2, 3, 4, 9.
- **Flush:** `count`=2, then `flush`=1 with `distinct`=1 in the same cycle.
  - Next cycle: `count` = 0, `issue_valid` = 0, `full` = 0.
  - `overflow_err` is unchanged and the strobed bundle never issues.
- **Wrap-around streaming:** push `pc` 0..9 on consecutive cycles with `issue_ready`=1.
  - `pc` 0..9 issue in order, one per cycle, each one cycle after its push.
  - `count` ≤ 1 throughout, and both pointers wrap twice.
- **Asynchronous reset:** assert `reset` between clock edges with `count`=3.
  - `issue_valid`, `full` and `count` go to 0 before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types: the decoded control/field bundle carried from decode to execute.
package cpu_pkg;

    typedef struct packed {
        logic        AorF;
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic [1:0]  ALUSrcs;
        logic        ALUSrcs2;
        logic [3:0]  ALUOp;
        logic [1:0]  RegDist;
        logic [1:0]  Branch;
        logic        MemWrite;
        logic        MemRead;
        logic        UARTtoReg;
        logic        RegtoUART;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] immediate;
        logic [25:0] inst_index;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/issue_queue_ram.sv
// Issue queue storage: one write port, one asynchronous read port, cleared on reset.
module issue_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/issue_queue.sv
// Decoded-instruction queue between decode and execute: in-order show-ahead FIFO with
// registered back-pressure, branch flush and a sticky overflow flag.
module issue_queue
    import cpu_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 15,
    parameter int DEPTH          = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  ctrl_t                     in_ctrl,
    input  logic [INST_MEM_WIDTH-1:0] in_pc,
    input  logic [INST_MEM_WIDTH-1:0] in_pc1,
    input  logic                      flush,
    output logic                      full,
    input  logic                      issue_ready,
    output logic                      issue_valid,
    output ctrl_t                     issue_ctrl,
    output logic [INST_MEM_WIDTH-1:0] issue_pc,
    output logic [INST_MEM_WIDTH-1:0] issue_pc1,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CTRL_W + 2 * INST_MEM_WIDTH;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_THR  = CW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] next_count;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] rd_data;

    assign issue_valid = (count != '0);

    // Flush wins over everything; a full queue still accepts a push when the head leaves.
    always_comb begin
        pop        = issue_valid && issue_ready && !flush;
        push       = distinct && !flush && ((count < DEPTH_C) || pop);
        drop       = distinct && !flush && (count == DEPTH_C) && !pop;
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (push && !pop) begin
            next_count = count + CW'(1);
        end else if (pop && !push) begin
            next_count = count - CW'(1);
        end
    end

    // full looks one entry ahead so decode's already-held bundle still has a slot.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= next_count;
            full  <= (next_count >= FULL_THR);
            if (drop) overflow_err <= 1'b1;
        end
    end

    issue_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .CLK     (CLK),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_ctrl, in_pc, in_pc1}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign {issue_ctrl, issue_pc, issue_pc1} = rd_data;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a reference occupancy model plus a scoreboard
// of accepted bundles that is popped and compared whenever the execute stage takes one.
module tb_issue_queue;
    import cpu_pkg::*;

    localparam int W     = 15;
    localparam int DEPTH = 4;

    typedef struct {
        ctrl_t        ctrl;
        logic [W-1:0] pc;
        logic [W-1:0] pc1;
    } entry_t;

    logic          CLK = 1'b0;
    logic          reset;
    logic          distinct;
    ctrl_t         in_ctrl;
    logic [W-1:0]  in_pc;
    logic [W-1:0]  in_pc1;
    logic          flush;
    logic          full;
    logic          issue_ready;
    logic          issue_valid;
    ctrl_t         issue_ctrl;
    logic [W-1:0]  issue_pc;
    logic [W-1:0]  issue_pc1;
    logic [2:0]    count;
    logic          overflow_err;

    int     checks   = 0;
    int     failures = 0;
    entry_t sb[$];
    int     model_count = 0;
    logic   model_full  = 1'b0;
    logic   model_ovf   = 1'b0;

    issue_queue #(.INST_MEM_WIDTH(W), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .distinct     (distinct),
        .in_ctrl      (in_ctrl),
        .in_pc        (in_pc),
        .in_pc1       (in_pc1),
        .flush        (flush),
        .full         (full),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .issue_ctrl   (issue_ctrl),
        .issue_pc     (issue_pc),
        .issue_pc1    (issue_pc1),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ctrl_t randCtrl();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[CTRL_W-1:0];
    endfunction

    // One clock cycle: drive inputs just after an edge, predict, then check after the next edge.
    task automatic applyStimulus(input logic d, input logic [W-1:0] pc, input logic rdy, input logic fl);
        entry_t e;
        entry_t exp_e;
        logic   do_pop;
        logic   do_push;
        e.ctrl = randCtrl();
        e.pc   = pc;
        e.pc1  = pc + W'(1);
        distinct    = d;
        in_ctrl     = e.ctrl;
        in_pc       = e.pc;
        in_pc1      = e.pc1;
        issue_ready = rdy;
        flush       = fl;
        #2;
        do_pop  = (model_count != 0) && rdy && !fl;
        do_push = d && !fl && ((model_count < DEPTH) || do_pop);
        if (do_pop) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 128'(sb.size()), 128'd1);
            end else begin
                exp_e = sb.pop_front();
                checkOutput("issue_valid_at_pop", 128'(issue_valid), 128'd1);
                checkOutput("issue_pc", 128'(issue_pc), 128'(exp_e.pc));
                checkOutput("issue_pc1", 128'(issue_pc1), 128'(exp_e.pc1));
                checkOutput("issue_ctrl", 128'(issue_ctrl), 128'(exp_e.ctrl));
            end
        end
        if (fl) begin
            sb.delete();
            model_count = 0;
        end else begin
            if (do_push) sb.push_back(e);
            if (d && (model_count == DEPTH) && !do_pop) model_ovf = 1'b1;
            model_count = model_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        model_full = (model_count >= DEPTH - 1);
        @(posedge CLK);
        #1;
        checkOutput("count", 128'(count), 128'(model_count));
        checkOutput("issue_valid", 128'(issue_valid), 128'(model_count != 0));
        checkOutput("full", 128'(full), 128'(model_full));
        checkOutput("overflow_err", 128'(overflow_err), 128'(model_ovf));
    endtask

    task automatic idleInputs();
        distinct    = 1'b0;
        flush       = 1'b0;
        issue_ready = 1'b0;
        in_ctrl     = '0;
        in_pc       = '0;
        in_pc1      = '0;
    endtask

    // Pulse reset between edges and confirm it acts before the next clock edge.
    task automatic asyncReset(input string tag);
        idleInputs();
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, "_valid"}, 128'(issue_valid), 128'd0);
        checkOutput({tag, "_full"}, 128'(full), 128'd0);
        checkOutput({tag, "_count"}, 128'(count), 128'd0);
        checkOutput({tag, "_ovf"}, 128'(overflow_err), 128'd0);
        checkOutput({tag, "_pc"}, 128'(issue_pc), 128'd0);
        checkOutput({tag, "_ctrl"}, 128'(issue_ctrl), 128'd0);
        #1;
        reset = 1'b0;
        sb.delete();
        model_count = 0;
        model_full  = 1'b0;
        model_ovf   = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        #12;
        checkOutput("rst_valid", 128'(issue_valid), 128'd0);
        checkOutput("rst_full", 128'(full), 128'd0);
        checkOutput("rst_count", 128'(count), 128'd0);
        checkOutput("rst_ovf", 128'(overflow_err), 128'd0);
        checkOutput("rst_pc", 128'(issue_pc), 128'd0);
        reset = 1'b0;
        @(posedge CLK);
        #1;

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
        checkOutput("fill_count", 128'(count), 128'd3);
        checkOutput("fill_full", 128'(full), 128'd1);
        checkOutput("fill_head", 128'(issue_pc), 128'd1);
        applyStimulus(1'b1, W'(4), 1'b0, 1'b0);
        checkOutput("ovf_accept_count", 128'(count), 128'd4);
        checkOutput("ovf_accept_flag", 128'(overflow_err), 128'd0);
        applyStimulus(1'b1, W'(5), 1'b0, 1'b0);
        checkOutput("ovf_drop_count", 128'(count), 128'd4);
        checkOutput("ovf_drop_flag", 128'(overflow_err), 128'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ovf_drained", 128'(sb.size()), 128'd0);

        $display("[TB] push and pop while full");
        asyncReset("rst_mid1");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, W'(9), 1'b1, 1'b0);
        checkOutput("pp_count", 128'(count), 128'd4);
        checkOutput("pp_ovf", 128'(overflow_err), 128'd0);
        checkOutput("pp_head", 128'(issue_pc), 128'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] flush");
        applyStimulus(1'b1, W'(21), 1'b0, 1'b0);
        applyStimulus(1'b1, W'(22), 1'b0, 1'b0);
        applyStimulus(1'b1, W'(23), 1'b1, 1'b1);
        checkOutput("flush_count", 128'(count), 128'd0);
        checkOutput("flush_valid", 128'(issue_valid), 128'd0);
        checkOutput("flush_full", 128'(full), 128'd0);
        checkOutput("flush_ovf", 128'(overflow_err), 128'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] wrap-around streaming");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, W'(i), 1'b1, 1'b0);
            checkOutput("stream_count_le1", 128'(count <= 3'd1), 128'd1);
            checkOutput("stream_head", 128'(issue_pc), 128'(i));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", 128'(sb.size()), 128'd0);

        $display("[TB] asynchronous reset with entries in flight");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, W'(30 + i), 1'b0, 1'b0);
        checkOutput("pre_rst_count", 128'(count), 128'd3);
        asyncReset("rst_mid2");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
